// File: rtl/weight_dbuf_ctrl_if.sv
// Weight double-buffer handshake bundle: weight stream in, SRAM bank controls out, PE read pacing.
// master = the sequencer that drives the bank controls; slave = stream source / SRAM / PE side.
// Pure wiring, no state.
interface weight_dbuf_ctrl_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 10
);
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic                       rd_ready;
  logic                       rdata_valid;
  logic                       switch_banks;
  logic                       wen;
  logic [BANK_ADDR_WIDTH-1:0] wadr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       ren;
  logic [BANK_ADDR_WIDTH-1:0] radr;

  modport master (
    input  in_valid, in_data, rd_ready,
    output in_ready, rdata_valid, switch_banks, wen, wadr, wdata, ren, radr
  );

  modport slave (
    output in_valid, in_data, rd_ready,
    input  in_ready, rdata_valid, switch_banks, wen, wadr, wdata, ren, radr
  );
endinterface

// File: rtl/weight_dbuf_ctrl.sv
// Weight double-buffer sequencer: fills the write bank from a stream, replays the read bank `repeat` times per tile.
// Latency: wen/wdata/ren are same-cycle with the handshake; rdata_valid trails ren by 1; swap/done fire the cycle after the enabling event.
// Backpressure: in_ready drops while the write bank is full or a swap is in progress; reads advance only when rd_ready is high.
// Optional perf counters behind `WEIGHT_DBUF_CTRL_PERF_EN (perf_starve_cycles, perf_stall_cycles).
module weight_dbuf_ctrl #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int BANK_DEPTH      = 288,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_en,
  input  logic [BANK_ADDR_WIDTH:0]   config_fill_count,
  input  logic [BANK_ADDR_WIDTH:0]   config_read_count,
  input  logic [CNT_WIDTH-1:0]       config_repeat,
  input  logic [CNT_WIDTH-1:0]       config_num_tiles,
  weight_dbuf_ctrl_if.master         bus,
  output logic                       busy,
  output logic                       done
`ifdef WEIGHT_DBUF_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_starve_cycles,
  output logic [31:0]                perf_stall_cycles
`endif
);

  localparam int CW = BANK_ADDR_WIDTH + 1;
  // Out-of-range counts are clamped so addresses can never leave the bank.
  localparam logic [CW-1:0] DEPTH_C = CW'(BANK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, SWAP, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]              cfg_fill, cfg_read;
  logic [CNT_WIDTH-1:0]       cfg_repeat, cfg_tiles;
  logic [BANK_ADDR_WIDTH-1:0] wcnt, rcnt;
  logic [CNT_WIDTH-1:0]       rep, wtile, rtile;
  logic                       wr_full, rd_done, rd_bank_valid, rdata_valid_q;

  logic in_ready_c, wen_c, ren_c, switch_c, done_c, busy_c;
  logic wr_last, rd_pass_end, rd_last, cfg_accept;

  // Handshakes, end-of-tile/pass detection and next state. Swap/done look at
  // this cycle's events so they fire on the very next cycle.
  always_comb begin
    state_nxt   = state;
    cfg_accept  = 1'b0;
    switch_c    = 1'b0;
    done_c      = 1'b0;
    busy_c      = (state != IDLE);
    in_ready_c  = (state == RUN) && !wr_full && (wtile < cfg_tiles);
    wen_c       = bus.in_valid && in_ready_c;
    ren_c       = (state == RUN) && rd_bank_valid && !rd_done && bus.rd_ready;
    wr_last     = wen_c && ({1'b0, wcnt} == (cfg_fill - CW'(1)));
    rd_pass_end = ren_c && ({1'b0, rcnt} == (cfg_read - CW'(1)));
    rd_last     = rd_pass_end && (rep == (cfg_repeat - CNT_WIDTH'(1)));
    case (state)
      IDLE: begin
        cfg_accept = config_en;
        if (config_en) state_nxt = RUN;
      end
      RUN: begin
        // Completion outranks swap; both cannot hold since no tile is left to fill.
        if ((rd_done || rd_last) && ((rtile + CNT_WIDTH'(rd_last)) == cfg_tiles))
          state_nxt = DONE;
        else if ((wr_full || wr_last) && (!rd_bank_valid || rd_done || rd_last))
          state_nxt = SWAP;
      end
      SWAP: begin
        switch_c  = 1'b1;
        state_nxt = RUN;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Config latch plus write/read counters and bank-status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_fill      <= '0;
      cfg_read      <= '0;
      cfg_repeat    <= '0;
      cfg_tiles     <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      rep           <= '0;
      wtile         <= '0;
      rtile         <= '0;
      wr_full       <= 1'b0;
      rd_done       <= 1'b0;
      rd_bank_valid <= 1'b0;
    end else begin
      if (cfg_accept) begin
        cfg_fill      <= (config_fill_count > DEPTH_C) ? DEPTH_C : config_fill_count;
        cfg_read      <= (config_read_count > DEPTH_C) ? DEPTH_C : config_read_count;
        cfg_repeat    <= config_repeat;
        cfg_tiles     <= config_num_tiles;
        wcnt          <= '0;
        rcnt          <= '0;
        rep           <= '0;
        wtile         <= '0;
        rtile         <= '0;
        wr_full       <= 1'b0;
        rd_done       <= 1'b0;
        rd_bank_valid <= 1'b0;
      end
      if (wen_c) begin
        if (wr_last) begin
          wcnt    <= '0;
          wr_full <= 1'b1;
          wtile   <= wtile + CNT_WIDTH'(1);
        end else begin
          wcnt <= wcnt + BANK_ADDR_WIDTH'(1);
        end
      end
      if (ren_c) begin
        if (rd_pass_end) begin
          rcnt <= '0;
          if (rd_last) begin
            rep     <= '0;
            rd_done <= 1'b1;
            rtile   <= rtile + CNT_WIDTH'(1);
          end else begin
            rep <= rep + CNT_WIDTH'(1);
          end
        end else begin
          rcnt <= rcnt + BANK_ADDR_WIDTH'(1);
        end
      end
      if (state == SWAP) begin
        wr_full       <= 1'b0;
        rd_done       <= 1'b0;
        rd_bank_valid <= 1'b1;
        rcnt          <= '0;
        rep           <= '0;
      end
    end
  end

  // SRAM read data arrives one cycle after ren.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_valid_q <= 1'b0;
    else        rdata_valid_q <= ren_c;
  end

`ifdef WEIGHT_DBUF_CTRL_PERF_EN
  // Saturating counters of PE starvation and writer stall cycles while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_starve_cycles <= '0;
      perf_stall_cycles  <= '0;
    end else if (cfg_accept) begin
      perf_starve_cycles <= '0;
      perf_stall_cycles  <= '0;
    end else if (state == RUN) begin
      if (bus.rd_ready && !ren_c && !(&perf_starve_cycles))
        perf_starve_cycles <= perf_starve_cycles + 32'd1;
      if (bus.in_valid && !in_ready_c && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.wen          = wen_c;
  assign bus.wadr         = wcnt;
  assign bus.wdata        = bus.in_data;
  assign bus.ren          = ren_c;
  assign bus.radr         = rcnt;
  assign bus.rdata_valid  = rdata_valid_q;
  assign bus.switch_banks = switch_c;
  assign busy             = busy_c;
  assign done             = done_c;

endmodule
